// File: rtl/punc_state_regs.sv
// PUnC architectural state: PC, IR, eight-entry register file, NZP and temp.
// Every update is driven by the control unit's per-cycle strobes; reads and address offsets are combinational.
module punc_state_regs #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IR_clr,
  input  logic        IR_ld,
  input  logic        PC_clr,
  input  logic        PC_ld,
  input  logic        PC_inc,
  input  logic [1:0]  PC_sel,
  input  logic [1:0]  RF_W_data_sel,
  input  logic        RF_W_addr_sel,
  input  logic        RF_Rp_addr_sel,
  input  logic        RF_W_wr,
  input  logic        RF_Rp_rd,
  input  logic        RF_Rq_rd,
  input  logic        temp_ld,
  input  logic        nzp_ld,
  input  logic        nzp_clr,
  input  logic [15:0] alu_out,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] rp_data,
  output logic [15:0] rq_data,
  output logic [15:0] temp,
  output logic [2:0]  nzp,
  output logic        nzp_match,
  output logic [15:0] pc_off9,
  output logic [15:0] rq_off6
);
  localparam int unsigned W      = 16;
  localparam int unsigned NREG   = 8;
  localparam int unsigned AW     = 3;

  logic [W-1:0]  pc_q, pc_d;
  logic [W-1:0]  ir_q, ir_d;
  logic [W-1:0]  temp_q, temp_d;
  logic [2:0]    nzp_q, nzp_d;
  logic [W-1:0]  rf_q [NREG];
  logic [W-1:0]  rf_d [NREG];

  logic [W-1:0]  pc_off11;
  logic [AW-1:0] rp_addr, rq_addr, w_addr;
  logic [W-1:0]  w_data;

  // Offsets and register reads, all from pre-edge state
  always_comb begin
    pc_off9   = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
    pc_off11  = pc_q + {{5{ir_q[10]}}, ir_q[10:0]};
    rp_addr   = RF_Rp_addr_sel ? ir_q[11:9] : ir_q[2:0];
    rq_addr   = ir_q[8:6];
    rp_data   = RF_Rp_rd ? rf_q[rp_addr] : '0;
    rq_data   = RF_Rq_rd ? rf_q[rq_addr] : '0;
    rq_off6   = rq_data + {{10{ir_q[5]}}, ir_q[5:0]};
    nzp_match = |(ir_q[11:9] & nzp_q);
    w_addr    = RF_W_addr_sel ? AW'(7) : ir_q[11:9];
    case (RF_W_data_sel)
      2'd0:    w_data = alu_out;
      2'd1:    w_data = dmem_rdata;
      2'd2:    w_data = pc_q;
      default: w_data = pc_off9;
    endcase
  end

  // Next-state for all architectural registers
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    temp_d = temp_q;
    nzp_d  = nzp_q;
    for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];

    if (PC_clr) begin
      pc_d = PC_RESET;
    end else if (PC_ld) begin
      case (PC_sel)
        2'd0:    pc_d = pc_off9;
        2'd1:    pc_d = pc_off11;
        2'd2:    pc_d = rq_data;
        default: pc_d = pc_q;
      endcase
    end else if (PC_inc) begin
      pc_d = pc_q + W'(1);
    end

    if (IR_clr)     ir_d = '0;
    else if (IR_ld) ir_d = dmem_rdata;

    if (temp_ld) temp_d = dmem_rdata;

    if (RF_W_wr) rf_d[w_addr] = w_data;

    // One-hot condition code from the write-data bus, even when no register is written
    if (nzp_clr) begin
      nzp_d = 3'b000;
    end else if (nzp_ld) begin
      if (w_data[W-1])         nzp_d = 3'b100;
      else if (w_data == '0)   nzp_d = 3'b010;
      else                     nzp_d = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= PC_RESET;
      ir_q   <= '0;
      temp_q <= '0;
      nzp_q  <= 3'b000;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      temp_q <= temp_d;
      nzp_q  <= nzp_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign pc   = pc_q;
  assign ir   = ir_q;
  assign temp = temp_q;
  assign nzp  = nzp_q;

endmodule
